// File: rtl/hash_core_arbiter_pkg.sv
// ------------------------------------------------------------------
// hash_arb_pkg : FSM encoding, CLOG2 helper and default watchdog limit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) ($clog2(x))
`endif

package hash_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam int c_default_timeout = 4095;

endpackage

`default_nettype wire

// File: rtl/hash_core_arbiter_if.sv
// ------------------------------------------------------------------
// hash_core_arbiter_if : client request/response bus plus core-side bus
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface hash_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 1024,
  parameter int OUT_W   = 256
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_msg_len;
  logic [NUM_REQ-1:0]      req_store_int;
  logic [NUM_REQ-1:0]      req_cont_int;
  logic [NUM_REQ-1:0]      req_lock;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [OUT_W-1:0]        rsp_data;
  logic                    rsp_err;
  logic                    core_start;
  logic [IN_W-1:0]         core_data_in;
  logic                    core_message_length;
  logic                    core_store_intermediate;
  logic                    core_continue_intermediate;
  logic                    core_done;
  logic                    core_busy;
  logic [OUT_W-1:0]        core_data_out;

  // Environment side: the hash clients and the sha256XMSS core.
  modport master (
    output req_valid, req_data, req_msg_len, req_store_int, req_cont_int, req_lock,
    output core_done, core_busy, core_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  core_start, core_data_in, core_message_length,
    input  core_store_intermediate, core_continue_intermediate
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_msg_len, req_store_int, req_cont_int, req_lock,
    input  core_done, core_busy, core_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output core_start, core_data_in, core_message_length,
    output core_store_intermediate, core_continue_intermediate
  );
endinterface

`default_nettype wire

// File: rtl/hash_core_arbiter_rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter : combinational round-robin priority encoder with lock mask
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [IDX_W-1:0]   i_ptr,
  input  wire logic [NUM_REQ-1:0] i_mask,
  output logic      [NUM_REQ-1:0] o_grant,
  output logic      [IDX_W-1:0]   o_idx,
  output logic                    o_any
);
  localparam logic [IDX_W:0] c_nreq = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] w_elig;
  logic [IDX_W:0]     w_pos;

  assign w_elig = i_req & i_mask;

  // Scan upward from the pointer with wrap; the first eligible bit wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_pos >= c_nreq) w_pos = w_pos - c_nreq;
      if (!o_any && w_elig[w_pos[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_pos[IDX_W-1:0];
      end
    end
    o_grant = {{(NUM_REQ-1){1'b0}}, o_any} << o_idx;
  end

endmodule

`default_nettype wire

// File: rtl/hash_core_arbiter.sv
// ------------------------------------------------------------------
// hash_core_arbiter : time-shares one sha256XMSS core among NUM_REQ clients
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hash_core_arbiter
  import hash_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 1024,
  parameter int OUT_W   = 256,
  parameter int TIMEOUT = c_default_timeout,
  parameter int IDX_W   = `CLOG2(NUM_REQ)
) (
  input  wire logic            io_mainClk,
  input  wire logic            io_systemReset,
  hash_core_arbiter_if.slave   bus,
  output logic [IDX_W-1:0]     owner,
  output logic                 arb_busy
);
  localparam int                    c_wd_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0]     c_timeout = c_wd_w'(TIMEOUT);
  localparam logic [NUM_REQ-1:0]    c_one     = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]      c_last    = IDX_W'(NUM_REQ - 1);

  arb_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, r_owner, w_win_idx;
  logic                r_lock_q, w_win_any, w_hs, w_wd_expired, w_core_start;
  logic [NUM_REQ-1:0]  w_mask, w_win_grant, w_req_ready, r_rsp_valid;
  logic [c_wd_w-1:0]   r_wd, w_wd_inc;
  logic [IN_W-1:0]     r_core_data;
  logic                r_msg_len, r_store_int, r_cont_int, r_rsp_err;
  logic [OUT_W-1:0]    r_rsp_data;

  // While locked only the lock owner may win, even if it is idle.
  assign w_mask       = r_lock_q ? (c_one << r_owner) : '1;
  assign w_wd_inc     = r_wd + 1'b1;
  assign w_wd_expired = (w_wd_inc == c_timeout);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .i_mask  (w_mask),
    .o_grant (w_win_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_win_any)
  );

  always_ff @(posedge io_mainClk or posedge io_systemReset) begin
    if (io_systemReset) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = '0;
    w_hs         = 1'b0;
    w_core_start = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!io_systemReset && w_win_any) begin
          w_req_ready = w_win_grant;
          w_hs        = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      // Start is gated by the live busy flag so it lands in the first idle cycle.
      ST_ISSUE: begin
        if (!bus.core_busy) begin
          w_core_start = 1'b1;
          w_state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: if (bus.core_done || w_wd_expired) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge io_mainClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_lock_q    <= 1'b0;
      r_wd        <= '0;
      r_core_data <= '0;
      r_msg_len   <= 1'b0;
      r_store_int <= 1'b0;
      r_cont_int  <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_hs) begin
        r_owner     <= w_win_idx;
        r_core_data <= bus.req_data[w_win_idx*IN_W +: IN_W];
        r_msg_len   <= bus.req_msg_len[w_win_idx];
        r_store_int <= bus.req_store_int[w_win_idx];
        r_cont_int  <= bus.req_cont_int[w_win_idx];
        r_lock_q    <= bus.req_lock[w_win_idx];
      end
      if (r_state == ST_ISSUE) r_wd <= '0;
      if (r_state == ST_WAIT) begin
        r_wd <= w_wd_inc;
        // A done arriving in the expiry cycle still delivers the digest.
        if (bus.core_done) begin
          r_rsp_data  <= bus.core_data_out;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= c_one << r_owner;
        end else if (w_wd_expired) begin
          r_rsp_data  <= '0;
          r_rsp_err   <= 1'b1;
          r_lock_q    <= 1'b0;
          r_rsp_valid <= c_one << r_owner;
        end
      end
      if (r_state == ST_RESP && !r_lock_q)
        r_rr_ptr <= (r_owner == c_last) ? '0 : r_owner + 1'b1;
    end
  end

  assign bus.req_ready                  = w_req_ready;
  assign bus.rsp_valid                  = r_rsp_valid;
  assign bus.rsp_data                   = r_rsp_data;
  assign bus.rsp_err                    = r_rsp_err;
  assign bus.core_start                 = w_core_start;
  assign bus.core_data_in               = r_core_data;
  assign bus.core_message_length        = r_msg_len;
  assign bus.core_store_intermediate    = r_store_int;
  assign bus.core_continue_intermediate = r_cont_int;
  assign owner                          = r_owner;
  assign arb_busy                       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hash_core_arbiter.sv
// ------------------------------------------------------------------
// tb_hash_core_arbiter : directed self-checking bench for hash_core_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_hash_core_arbiter;
  localparam int NR = 4;
  localparam int IW = 128;
  localparam int OW = 256;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] owner;
  logic       arb_busy;
  int n_pass = 0;
  int n_chk  = 0;
  logic [IW-1:0] dat [NR];
  logic [OW-1:0] dig_a5;
  logic [3:0]    oh;
  logic          start_seen;
  int            exp_i;

  hash_core_arbiter_if #(.NUM_REQ(NR), .IN_W(IW), .OUT_W(OW)) bus ();

  hash_core_arbiter #(
    .NUM_REQ(NR), .IN_W(IW), .OUT_W(OW), .TIMEOUT(TO), .IDX_W(2)
  ) dut (
    .io_mainClk     (clk),
    .io_systemReset (rst),
    .bus            (bus.slave),
    .owner          (owner),
    .arb_busy       (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called in the core_start cycle S; returns in cycle D+1 where D = S+lat.
  task automatic core_resp(input int lat, input logic [OW-1:0] dig);
    tick();
    chk("start_single_pulse", OW'(bus.core_start), OW'(1'b0));
    repeat (lat - 1) tick();
    chk("no_early_rsp", OW'(bus.rsp_valid), OW'(4'b0000));
    bus.core_done     = 1'b1;
    bus.core_data_out = dig;
    tick();
    bus.core_done     = 1'b0;
    bus.core_data_out = '0;
    chk("ready_low_in_resp", OW'(bus.req_ready), OW'(4'b0000));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    bus.req_valid = '0; bus.req_msg_len = '0; bus.req_store_int = '0;
    bus.req_cont_int = '0; bus.req_lock = '0; bus.core_done = 1'b0;
    bus.core_busy = 1'b0; bus.core_data_out = '0; bus.req_data = '0;
    for (int i = 0; i < NR; i++) begin
      dat[i] = {4{32'hC0DE_0000 + 32'(i)}};
      bus.req_data[i*IW +: IW] = dat[i];
    end
    dig_a5 = {32{8'hA5}};

    // Reset state, with a pending request that must not be acknowledged
    tick(); tick();
    bus.req_valid = 4'b0001; #1;
    chk("rst_req_ready",  OW'(bus.req_ready),  OW'(4'b0000));
    chk("rst_rsp_valid",  OW'(bus.rsp_valid),  OW'(4'b0000));
    chk("rst_core_start", OW'(bus.core_start), OW'(1'b0));
    chk("rst_owner",      OW'(owner),          OW'(2'd0));
    chk("rst_arb_busy",   OW'(arb_busy),       OW'(1'b0));
    bus.req_valid = '0;
    rst = 1'b0;

    // Single request from requester 1, core latency 80
    tick();
    bus.req_valid = 4'b0010; bus.req_msg_len = 4'b0010; #1;
    chk("t1_ready", OW'(bus.req_ready), OW'(4'b0010));
    tick();
    bus.req_valid = '0; bus.req_msg_len = '0;
    chk("t1_start",     OW'(bus.core_start),          OW'(1'b1));
    chk("t1_owner",     OW'(owner),                   OW'(2'd1));
    chk("t1_data_in",   OW'(bus.core_data_in),        OW'(dat[1]));
    chk("t1_msg_len",   OW'(bus.core_message_length), OW'(1'b1));
    chk("t1_busy_flag", OW'(arb_busy),                OW'(1'b1));
    core_resp(80, dig_a5);
    chk("t1_rsp_valid", OW'(bus.rsp_valid), OW'(4'b0010));
    chk("t1_rsp_data",  bus.rsp_data,       dig_a5);
    chk("t1_rsp_err",   OW'(bus.rsp_err),   OW'(1'b0));
    tick();
    chk("t1_rsp_pulse", OW'(bus.rsp_valid), OW'(4'b0000));
    chk("t1_rsp_hold",  bus.rsp_data,       dig_a5);
    chk("t1_idle",      OW'(arb_busy),      OW'(1'b0));

    // Core busy for 10 cycles in ISSUE; requester data changes meanwhile
    bus.core_busy = 1'b1; bus.req_valid = 4'b0010; #1;
    chk("t2_ready", OW'(bus.req_ready), OW'(4'b0010));
    tick();
    bus.req_valid = '0;
    bus.req_data[1*IW +: IW] = ~dat[1];
    start_seen = 1'b0;
    repeat (10) begin
      start_seen = start_seen | bus.core_start;
      tick();
    end
    bus.core_busy = 1'b0; #1;
    chk("t2_no_start_while_busy", OW'(start_seen),     OW'(1'b0));
    chk("t2_start_first_idle",    OW'(bus.core_start), OW'(1'b1));
    chk("t2_data_stable",         OW'(bus.core_data_in), OW'(dat[1]));
    core_resp(5, OW'(32'h0000_B0B0));
    chk("t2_rsp_valid", OW'(bus.rsp_valid), OW'(4'b0010));
    bus.req_data[1*IW +: IW] = dat[1];
    tick();

    // Lock: requester 2 twice while 0 and 3 wait, then 3, then 0
    bus.req_valid = 4'b1101; bus.req_lock = 4'b0100; bus.req_store_int = 4'b0100; #1;
    chk("t3_ready_a", OW'(bus.req_ready), OW'(4'b0100));
    tick();
    bus.req_valid = 4'b1001; bus.req_lock = '0; bus.req_store_int = '0;
    chk("t3_owner_a", OW'(owner),                       OW'(2'd2));
    chk("t3_store",   OW'(bus.core_store_intermediate), OW'(1'b1));
    core_resp(4, OW'(32'h0000_3A3A));
    chk("t3_rsp_a", OW'(bus.rsp_valid), OW'(4'b0100));
    tick();
    chk("t3_lock_hold", OW'(bus.req_ready), OW'(4'b0000));
    tick();
    chk("t3_lock_hold2", OW'(bus.req_ready), OW'(4'b0000));
    bus.req_valid = 4'b1101; bus.req_cont_int = 4'b0100; #1;
    chk("t3_ready_b", OW'(bus.req_ready), OW'(4'b0100));
    tick();
    bus.req_valid = 4'b1001; bus.req_cont_int = '0;
    chk("t3_owner_b", OW'(owner),                          OW'(2'd2));
    chk("t3_cont",    OW'(bus.core_continue_intermediate), OW'(1'b1));
    chk("t3_store_b", OW'(bus.core_store_intermediate),    OW'(1'b0));
    core_resp(4, OW'(32'h0000_3B3B));
    chk("t3_rsp_b", OW'(bus.rsp_valid), OW'(4'b0100));
    tick();
    chk("t3_ready_c", OW'(bus.req_ready), OW'(4'b1000));
    tick();
    bus.req_valid = 4'b0001;
    chk("t3_owner_c", OW'(owner), OW'(2'd3));
    core_resp(4, OW'(32'h0000_3C3C));
    chk("t3_rsp_c", OW'(bus.rsp_valid), OW'(4'b1000));
    tick();
    chk("t3_ready_d", OW'(bus.req_ready), OW'(4'b0001));
    tick();
    bus.req_valid = '0;
    chk("t3_owner_d", OW'(owner), OW'(2'd0));
    core_resp(4, OW'(32'h0000_3D3D));
    chk("t3_rsp_d", OW'(bus.rsp_valid), OW'(4'b0001));
    tick();

    // Watchdog: locked request from 1, core never finishes
    bus.req_valid = 4'b0010; bus.req_lock = 4'b0010; #1;
    chk("t4_ready", OW'(bus.req_ready), OW'(4'b0010));
    tick();
    bus.req_valid = '0; bus.req_lock = '0;
    chk("t4_start", OW'(bus.core_start), OW'(1'b1));
    repeat (TO) tick();
    chk("t4_no_early", OW'(bus.rsp_valid), OW'(4'b0000));
    tick();
    chk("t4_rsp_valid", OW'(bus.rsp_valid), OW'(4'b0010));
    chk("t4_rsp_err",   OW'(bus.rsp_err),   OW'(1'b1));
    chk("t4_rsp_data",  bus.rsp_data,       OW'(0));
    tick();
    bus.req_valid = 4'b1000; #1;
    chk("t4_lock_cleared", OW'(bus.req_ready), OW'(4'b1000));

    // Asynchronous reset while waiting on the core
    tick();
    bus.req_valid = '0;
    chk("t5_owner", OW'(owner), OW'(2'd3));
    tick();
    chk("t5_in_wait", OW'(arb_busy), OW'(1'b1));
    #3;
    rst = 1'b1; bus.req_valid = 4'b1111; #1;
    chk("t5_rst_ready",   OW'(bus.req_ready),    OW'(4'b0000));
    chk("t5_rst_err",     OW'(bus.rsp_err),      OW'(1'b0));
    chk("t5_rst_owner",   OW'(owner),            OW'(2'd0));
    chk("t5_rst_busy",    OW'(arb_busy),         OW'(1'b0));
    chk("t5_rst_data_in", OW'(bus.core_data_in), OW'(0));
    chk("t5_rst_start",   OW'(bus.core_start),   OW'(1'b0));
    tick();
    rst = 1'b0; #1;

    // Fairness with all four requesting: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      exp_i = k % NR;
      oh = 4'b0001 << exp_i;
      chk("t6_ready", OW'(bus.req_ready), OW'(oh));
      tick();
      chk("t6_owner",   OW'(owner),              OW'(exp_i));
      chk("t6_data_in", OW'(bus.core_data_in),   OW'(dat[exp_i]));
      core_resp(3, OW'(k + 1));
      chk("t6_rsp_valid", OW'(bus.rsp_valid), OW'(oh));
      chk("t6_rsp_data",  bus.rsp_data,       OW'(k + 1));
      tick();
    end
    bus.req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
